multiword_add_ctrl: RTL and testbench

Sequencer that performs a wide addition (BITS*WORDS bits) by time-multiplexing a single BITS-wide ripple adder over WORDS cycles, least-significant word first. The carry is held in a register between cycles. It sits between a requester issuing start/operand pulses and the shared adder datapath. It exposes a ready/done handshake and registered, stable results.

---
 rtl/multiword_add_ctrl.sv | 117 +++++++++++
 tb/tb_multiword_add_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/multiword_add_ctrl.sv
// Wide adder sequencer: one BITS-wide ripple slice reused over WORDS cycles,
// least-significant word first, with the inter-word carry held in a register.
module multiword_add_ctrl #(
  parameter int BITS  = 8,
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  clear,
  input  logic [BITS*WORDS-1:0] a,
  input  logic [BITS*WORDS-1:0] b,
  input  logic                  carry_in,
  output logic                  ready,
  output logic                  busy,
  output logic                  done,
  output logic [BITS*WORDS-1:0] sum,
  output logic                  carry_out
);

  localparam int W  = BITS * WORDS;
  localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [W-1:0]    a_sh, b_sh, work, work_nxt;
  logic            c_reg;
  logic [CW-1:0]   cnt;
  logic [BITS:0]   result;
  logic            last;

  assign result = {1'b0, a_sh[BITS-1:0]} + {1'b0, b_sh[BITS-1:0]} + {{BITS{1'b0}}, c_reg};
  assign last   = (cnt == CW'(WORDS - 1));

  // The new slice enters at the top so that after WORDS shifts the least
  // significant slice has reached bit 0.
  generate
    if (WORDS == 1) begin : g_single
      assign work_nxt = result[BITS-1:0];
    end else begin : g_multi
      assign work_nxt = {result[BITS-1:0], work[W-1:BITS]};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every variable assigned in always_comb gets a default first so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN: begin
        if (clear)     state_nxt = IDLE;
        else if (last) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: the operand shift registers and work register are plain flops, not
  // RAM, so they are reset with everything else and never hold X.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh      <= '0;
      b_sh      <= '0;
      work      <= '0;
      c_reg     <= 1'b0;
      cnt       <= '0;
      sum       <= '0;
      carry_out <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            c_reg <= carry_in;
            cnt   <= '0;
          end
        end
        RUN: begin
          if (clear) begin
            cnt <= '0;
          end else begin
            a_sh  <= a_sh >> BITS;
            b_sh  <= b_sh >> BITS;
            work  <= work_nxt;
            c_reg <= result[BITS];
            cnt   <= last ? '0 : cnt + CW'(1);
            if (last) begin
              sum       <= work_nxt;
              carry_out <= result[BITS];
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign ready = (state == IDLE);
  assign busy  = (state == RUN);
  assign done  = (state == DONE);

endmodule

// File: tb/tb_multiword_add_ctrl.sv
// Self-checking bench for multiword_add_ctrl: a cycle-level behavioural model
// compared every cycle, plus hand-computed literal expectations.
module tb_multiword_add_ctrl;

  localparam int BITS  = 8;
  localparam int WORDS = 4;
  localparam int W     = BITS * WORDS;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         clear = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         carry_in = 1'b0;
  logic         ready, busy, done, carry_out;
  logic [W-1:0] sum;

  int checks = 0;
  int errors = 0;
  int edge_cnt = 0;

  multiword_add_ctrl #(.BITS(BITS), .WORDS(WORDS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .clear     (clear),
    .a         (a),
    .b         (b),
    .carry_in  (carry_in),
    .ready     (ready),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .carry_out (carry_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: the whole result is plain wide arithmetic computed at
  // acceptance and published after WORDS busy cycles.
  int           m_mode;   // 0 idle, 1 busy, 2 done
  int           m_left;
  logic [W:0]   m_res;
  logic [W-1:0] m_sum;
  logic         m_co;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode <= 0;
      m_left <= 0;
      m_res  <= '0;
      m_sum  <= '0;
      m_co   <= 1'b0;
    end else begin
      case (m_mode)
        0: if (start) begin
          m_res  <= {1'b0, a} + {1'b0, b} + {{W{1'b0}}, carry_in};
          m_left <= WORDS;
          m_mode <= 1;
        end
        1: if (clear) begin
          m_mode <= 0;
        end else if (m_left == 1) begin
          m_sum  <= m_res[W-1:0];
          m_co   <= m_res[W];
          m_mode <= 2;
        end else begin
          m_left <= m_left - 1;
        end
        default: m_mode <= 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("ready", ready, (m_mode == 0));
      check("busy", busy, (m_mode == 1));
      check("done", done, (m_mode == 2));
      check("sum", sum, m_sum);
      check("carry_out", carry_out, m_co);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Leaves the bench at the negedge of the first busy cycle; returns the edge
  // index at which the start was accepted.
  task automatic start_op(input logic [W-1:0] op_a, input logic [W-1:0] op_b,
                          input logic cin, output int acc_edge);
    @(negedge clk);
    check("ready_before_start", ready, 1'b1);
    a = op_a; b = op_b; carry_in = cin; start = 1'b1;
    acc_edge = edge_cnt + 1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Returns at the negedge where done is observed high.
  task automatic wait_done(output int busy_cycles, output int done_edge);
    bit seen = 0;
    busy_cycles = 0;
    done_edge = -1;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        seen = 1;
        done_edge = edge_cnt;
        break;
      end
      if (busy) busy_cycles++;
      @(negedge clk);
    end
    if (!seen) check("done_timeout", 1'b0, 1'b1);
  endtask

  initial begin
    int acc, dedge, bcyc, first_acc, second_acc;
    bit saw_done;

    // 1. reset
    #23;
    check("rst_ready", ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_sum", sum, 32'h0);
    check("rst_co", carry_out, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // 2. carry between words
    start_op(32'h0000_00FF, 32'h0000_0001, 1'b0, acc);
    wait_done(bcyc, dedge);
    check("t2_busy_cycles", bcyc, WORDS);
    check("t2_done_latency", dedge - acc, WORDS);
    check("t2_sum", sum, 32'h0000_0100);
    check("t2_co", carry_out, 1'b0);

    // 3. ripple through all four words
    start_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, acc);
    wait_done(bcyc, dedge);
    check("t3_sum", sum, 32'h0000_0000);
    check("t3_co", carry_out, 1'b1);

    // 4. general add with start held high back-to-back
    @(negedge clk);
    a = 32'h1234_5678; b = 32'h9ABC_DEF0; carry_in = 1'b0; start = 1'b1;
    first_acc = edge_cnt + 1;
    second_acc = -1;
    saw_done = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin
        saw_done = 1;
        check("t4_done_latency", edge_cnt - first_acc, WORDS);
        check("t4_sum", sum, 32'hACF1_3568);
        check("t4_co", carry_out, 1'b0);
      end
      if (ready) begin
        second_acc = edge_cnt + 1;
        break;
      end
    end
    check("t4_saw_done", saw_done, 1'b1);
    check("t4_reaccept_gap", second_acc - first_acc, WORDS + 2);
    @(negedge clk);
    start = 1'b0;
    wait_done(bcyc, dedge);
    check("t4b_sum", sum, 32'hACF1_3568);

    // 5a. clear in the second busy cycle
    start_op(32'h1, 32'h1, 1'b0, acc);
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("t5_ready_after_clear", ready, 1'b1);
    saw_done = 0;
    for (int i = 0; i < 6; i++) begin
      if (done) saw_done = 1;
      @(negedge clk);
    end
    check("t5_no_done", saw_done, 1'b0);
    check("t5_sum_held", sum, 32'hACF1_3568);
    check("t5_co_held", carry_out, 1'b0);

    // 5b. start with new operands during busy is ignored
    start_op(32'h3, 32'h4, 1'b0, acc);
    a = 32'h100; b = 32'h100; carry_in = 1'b1; start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    wait_done(bcyc, dedge);
    check("t5b_sum", sum, 32'h0000_0007);
    check("t5b_co", carry_out, 1'b0);

    // 6. asynchronous reset mid-operation
    start_op(32'hFFFF_FFFF, 32'h1, 1'b0, acc);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_ready", ready, 1'b1);
    check("t6_busy", busy, 1'b0);
    check("t6_done", done, 1'b0);
    check("t6_sum", sum, 32'h0);
    check("t6_co", carry_out, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    start_op(32'h1, 32'h1, 1'b0, acc);
    wait_done(bcyc, dedge);
    check("t6_post_sum", sum, 32'h0000_0002);
    check("t6_post_co", carry_out, 1'b0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
